// File: rtl/mealy_cnt_det.sv
// Up/down wrap-or-saturate counter with Mealy match detect and
// a saturating hit counter; sync active-low reset.
module mealy_cnt_det #(
   parameter int WIDTH = 2,
   parameter int MATCH = 2,
   parameter int HCW   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             y,
   output logic             wrap,
   output logic             sat,
   output logic [HCW-1:0]   hits
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      LOADED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MAXV    = '1;
   localparam logic [WIDTH-1:0] MATCH_V = WIDTH'(MATCH);
   localparam logic [HCW-1:0]   HMAX    = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             sat_q, sat_d;
   logic [HCW-1:0]   hits_q, hits_d;
   logic             at_edge;
   logic [WIDTH-1:0] step;

   assign y = rst & x & ~load & (out_q == MATCH_V);

   // at_edge: the next count in the current direction crosses a boundary
   assign at_edge = dir ? (out_q == '0) : (out_q == MAXV);
   assign step    = dir ? (out_q - 1'b1) : (out_q + 1'b1);

   always_comb begin
      out_d   = out_q;
      wrap_d  = 1'b0;
      state_d = state_q;
      unique case (1'b1)
         load: begin
            out_d   = load_val;
            state_d = LOADED;
         end
         (!load && x && at_edge && mode): begin
            state_d = HOLD;
         end
         (!load && x && !(at_edge && mode)): begin
            out_d   = step;
            wrap_d  = at_edge;
            state_d = RUN;
         end
         (!load && !x): begin
            if (state_q == LOADED || (state_q == HOLD && !mode))
               state_d = RUN;
         end
         default: state_d = state_q;
      endcase
      sat_d  = (state_d == HOLD);
      hits_d = (y && hits_q != HMAX) ? hits_q + 1'b1 : hits_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         out_q   <= '0;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
         hits_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
         hits_q  <= hits_d;
      end
   end

   assign out  = out_q;
   assign wrap = wrap_q;
   assign sat  = sat_q;
   assign hits = hits_q;

endmodule
